// File: rtl/leaf_nu_pkg.sv
// Shared types and helpers for the leaf_nu multi-lane theta/iota combine block.
// Holds the combine-mode encoding and a width/amount-generic rotate-left.
package leaf_nu_pkg;

  typedef enum logic [1:0] {MODE_ADD, MODE_SUB, MODE_XOR, MODE_PASS} nu_mode_e;

  localparam int unsigned NU_MAX_W = 64;

  // Rotate the low w bits of x left by amt; bits at and above w are returned as zero.
  function automatic logic [NU_MAX_W-1:0] rotl(input logic [NU_MAX_W-1:0] x,
                                               input int unsigned w,
                                               input int unsigned amt);
    logic [NU_MAX_W-1:0] mask;
    logic [NU_MAX_W-1:0] xm;
    mask = (w >= NU_MAX_W) ? '1 : ((NU_MAX_W'(1) << w) - NU_MAX_W'(1));
    xm   = x & mask;
    return ((xm << amt) | (xm >> (w - amt))) & mask;
  endfunction

endpackage

// File: rtl/leaf_nu_lane.sv
// One lane of leaf_nu: stage-1 theta/iota terms with sample history,
// stage-2 mode-selected combine XORed with the original sample.
module leaf_nu_lane
  import leaf_nu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ROT   = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             s1_ld_i,
  input  logic             s2_ld_i,
  input  nu_mode_e         mode_i,
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH-1:0] y_o
);

  logic [WIDTH-1:0] x1_q, t_q, i_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] t_d;

  function automatic logic [WIDTH-1:0] combine(input nu_mode_e m,
                                               input logic [WIDTH-1:0] t,
                                               input logic [WIDTH-1:0] i);
    case (m)
      MODE_ADD: return t + i;
      MODE_SUB: return t - i;
      MODE_XOR: return t ^ i;
      default:  return t;
    endcase
  endfunction

  assign t_d = WIDTH'(rotl(NU_MAX_W'(x_i), WIDTH, ROT));
  assign y_d = combine(mode_i, t_q, i_q) ^ x1_q;

  // Stage 1: only loaded on accept, so stale contents never reach the output.
  always_ff @(posedge clk_i) begin
    if (s1_ld_i) begin
      x1_q <= x_i;
      t_q  <= t_d;
      i_q  <= x_i ^ prev_q;
    end
  end

  // History and stage 2: cleared on reset; history also cleared on flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= '0;
      y_q    <= '0;
    end else begin
      if (flush_i)      prev_q <= '0;
      else if (s1_ld_i) prev_q <= x_i;
      if (s2_ld_i)      y_q    <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/leaf_nu.sv
// Multi-lane pipelined theta/iota combine leaf with valid/ready backpressure,
// synchronous flush and a wrapping output transfer counter.
module leaf_nu
  import leaf_nu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 4,
  parameter int ROT   = 1,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [1:0]             in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]       out_count
);

  if (ROT < 0 || ROT >= WIDTH || WIDTH > int'(NU_MAX_W)) begin : g_bad_param
    $error("leaf_nu: ROT must be in 0..WIDTH-1 and WIDTH at most 64");
  end

  logic             s1_valid_q, s1_valid_d;
  logic             out_valid_q, out_valid_d;
  nu_mode_e         mode1_q, mode1_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             s1_en, s2_en, accept, xfer, s2_ld;

  assign s2_en    = !out_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en && !flush;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready && !flush;
  assign s2_ld    = s2_en && s1_valid_q && !flush;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    mode1_d     = mode1_q;
    count_d     = count_q;
    if (flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (s2_en)  out_valid_d = s1_valid_q;
      if (s1_en)  s1_valid_d  = in_valid;
      if (accept) mode1_d     = nu_mode_e'(in_mode);
      if (xfer)   count_d     = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      mode1_q     <= MODE_ADD;
      count_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      mode1_q     <= mode1_d;
      count_q     <= count_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    leaf_nu_lane #(
      .WIDTH(WIDTH),
      .ROT  (ROT)
    ) u_lane (
      .clk_i  (clk),
      .rst_i  (rst),
      .flush_i(flush),
      .s1_ld_i(accept),
      .s2_ld_i(s2_ld),
      .mode_i (mode1_q),
      .x_i    (in_data[k*WIDTH +: WIDTH]),
      .y_o    (out_data[k*WIDTH +: WIDTH])
    );
  end

  assign out_valid = out_valid_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_leaf_nu.sv
// Self-checking bench for leaf_nu (WIDTH=8, LANES=2, ROT=1, CNT_W=4) with a
// transaction-level reference model and directed plus randomized scenarios.
module tb_leaf_nu;

  localparam int W  = 8;
  localparam int L  = 2;
  localparam int R  = 1;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [L*W-1:0] in_data = '0;
  logic [1:0]    in_mode = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [L*W-1:0] out_data;
  logic [CW-1:0] out_count;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  bit             m_s1v, m_s2v;
  logic [L*W-1:0] m_s1d, m_s2d;
  logic [W-1:0]   m_prev [L];
  logic [CW-1:0]  m_cnt;

  logic           exp_ready, exp_ov, obs_ready, obs_ov;
  logic [L*W-1:0] exp_od, obs_od;
  logic [CW-1:0]  exp_cnt, obs_cnt;

  leaf_nu #(.WIDTH(W), .LANES(L), .ROT(R), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  // Expected result for one accepted sample, advancing the per-lane history.
  function automatic logic [L*W-1:0] ref_sample(input logic [L*W-1:0] d, input logic [1:0] m);
    logic [L*W-1:0] r;
    int xi, t, i, c;
    for (int k = 0; k < L; k++) begin
      xi = int'(d[k*W +: W]);
      t  = ((xi << R) | (xi >> (W - R))) & 255;
      i  = xi ^ int'(m_prev[k]);
      case (m)
        2'd0: c = (t + i) % 256;
        2'd1: c = (t - i + 256) % 256;
        2'd2: c = t ^ i;
        default: c = t;
      endcase
      r[k*W +: W] = 8'((c ^ xi) & 255);
      m_prev[k]   = d[k*W +: W];
    end
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b1;
    m_s1v = 0; m_s2v = 0; m_s1d = '0; m_s2d = '0; m_cnt = '0;
    for (int k = 0; k < L; k++) m_prev[k] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Apply one cycle of inputs, record observed/expected values, advance the model.
  task automatic tick(input logic v, input logic [L*W-1:0] d, input logic [1:0] m,
                      input logic ordy, input logic fl);
    bit s2en, s1en, acc, xf;
    @(negedge clk);
    in_valid = v; in_data = d; in_mode = m; out_ready = ordy; flush = fl;
    #1;
    exp_ready = !fl && (!m_s1v || !m_s2v || ordy);
    exp_ov = m_s2v; exp_od = m_s2d; exp_cnt = m_cnt;
    obs_ready = in_ready; obs_ov = out_valid; obs_od = out_data; obs_cnt = out_count;
    if (fl) begin
      m_s1v = 0; m_s2v = 0;
      for (int k = 0; k < L; k++) m_prev[k] = '0;
    end else begin
      xf   = m_s2v && ordy;
      s2en = !m_s2v || ordy;
      s1en = !m_s1v || s2en;
      acc  = v && exp_ready;
      if (xf) m_cnt = m_cnt + 1'b1;
      if (s2en) begin
        if (m_s1v) m_s2d = m_s1d;
        m_s2v = m_s1v;
      end
      if (s1en) m_s1v = acc;
      if (acc) m_s1d = ref_sample(d, m);
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_chk++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_chk++; if (out_count !== '0) begin n_fail++; $display("FAIL reset_out_count got %0d want 0", out_count); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add_mode();
    do_reset();
    tick(1, 16'h0081, 2'd0, 1, 0);
    tick(1, 16'h0001, 2'd0, 1, 0);
    n_chk++; if (obs_ov !== 1'b0) begin n_fail++; $display("FAIL add_latency out_valid got %b want 0", obs_ov); end
    tick(0, '0, 2'd0, 1, 0);
    n_chk++; if (obs_ov !== 1'b1 || obs_od !== 16'h0005) begin n_fail++; $display("FAIL add_first got v=%b %h want v=1 0005", obs_ov, obs_od); end
    tick(0, '0, 2'd0, 1, 0);
    n_chk++; if (obs_ov !== 1'b1 || obs_od !== 16'h0083) begin n_fail++; $display("FAIL add_second got v=%b %h want v=1 0083", obs_ov, obs_od); end
    tick(0, '0, 2'd0, 1, 0);
    n_chk++; if (obs_ov !== 1'b0 || obs_cnt !== 4'd2) begin n_fail++; $display("FAIL add_count got v=%b cnt=%0d want v=0 cnt=2", obs_ov, obs_cnt); end
  endtask

  task automatic test_modes();
    do_reset();
    tick(1, 16'h0010, 2'd1, 1, 0);
    tick(1, 16'h0010, 2'd3, 1, 0);
    tick(0, '0, 2'd0, 1, 0);
    n_chk++; if (obs_ov !== 1'b1 || obs_od[7:0] !== 8'h00) begin n_fail++; $display("FAIL mode_sub got v=%b %h want v=1 00", obs_ov, obs_od[7:0]); end
    tick(0, '0, 2'd0, 1, 0);
    n_chk++; if (obs_ov !== 1'b1 || obs_od[7:0] !== 8'h30) begin n_fail++; $display("FAIL mode_pass got v=%b %h want v=1 30", obs_ov, obs_od[7:0]); end
  endtask

  task automatic test_lanes();
    do_reset();
    tick(1, 16'hFF81, 2'd2, 1, 0);
    tick(0, '0, 2'd0, 1, 0);
    tick(0, '0, 2'd0, 1, 0);
    n_chk++; if (obs_ov !== 1'b1 || obs_od !== 16'hFF03) begin n_fail++; $display("FAIL lanes_xor got v=%b %h want v=1 ff03", obs_ov, obs_od); end
  endtask

  task automatic test_backpressure();
    logic [L*W-1:0] smp [8];
    logic [1:0]     md  [8];
    int idx, c;
    bit saw_low, done;
    do_reset();
    for (int j = 0; j < 8; j++) begin smp[j] = 16'($urandom); md[j] = 2'($urandom_range(0, 3)); end
    idx = 0; saw_low = 0; done = 0;
    for (c = 0; c < 60 && !done; c++) begin
      tick(idx < 8, (idx < 8) ? smp[idx] : '0, (idx < 8) ? md[idx] : 2'd0, !(c >= 3 && c < 8), 0);
      n_chk++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL bp_in_ready cyc %0d got %b want %b", c, obs_ready, exp_ready); end
      n_chk++; if (obs_ov !== exp_ov) begin n_fail++; $display("FAIL bp_out_valid cyc %0d got %b want %b", c, obs_ov, exp_ov); end
      if (exp_ov) begin
        n_chk++; if (obs_od !== exp_od) begin n_fail++; $display("FAIL bp_out_data cyc %0d got %h want %h", c, obs_od, exp_od); end
      end
      if (obs_ready === 1'b0) saw_low = 1;
      if (idx < 8 && exp_ready) idx++;
      done = (idx == 8) && !m_s1v && !m_s2v;
    end
    n_chk++; if (!done) begin n_fail++; $display("FAIL bp_drain got undrained want drained within 60 cycles"); end
    n_chk++; if (!saw_low) begin n_fail++; $display("FAIL bp_ready_drop got never-low want low while stalled"); end
    tick(0, '0, 2'd0, 1, 0);
    n_chk++; if (obs_cnt !== 4'd8) begin n_fail++; $display("FAIL bp_count got %0d want 8", obs_cnt); end
  endtask

  task automatic test_flush();
    logic [CW-1:0] cnt_pre;
    do_reset();
    for (int j = 0; j < 3; j++) tick(1, 16'($urandom), 2'($urandom_range(0, 3)), 1, 0);
    tick(1, 16'h1234, 2'd0, 0, 0);
    tick(1, 16'h5678, 2'd0, 0, 0);
    tick(1, 16'h9ABC, 2'd0, 0, 1);
    cnt_pre = exp_cnt;
    n_chk++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %b want 0", obs_ready); end
    tick(0, '0, 2'd0, 1, 0);
    n_chk++; if (obs_ov !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %b want 0", obs_ov); end
    n_chk++; if (obs_cnt !== cnt_pre) begin n_fail++; $display("FAIL flush_count got %0d want %0d", obs_cnt, cnt_pre); end
    tick(1, 16'h0081, 2'd0, 1, 0);
    tick(0, '0, 2'd0, 1, 0);
    tick(0, '0, 2'd0, 1, 0);
    n_chk++; if (obs_ov !== 1'b1 || obs_od !== 16'h0005) begin n_fail++; $display("FAIL flush_history got v=%b %h want v=1 0005", obs_ov, obs_od); end
  endtask

  task automatic test_async_reset_wrap();
    do_reset();
    for (int j = 0; j < 4; j++) tick(1, 16'($urandom), 2'($urandom_range(0, 3)), 1, 0);
    #2; rst = 1'b1; #1;
    n_chk++; if (out_valid !== 1'b0 || out_data !== '0 || out_count !== '0) begin
      n_fail++; $display("FAIL async_reset got v=%b d=%h cnt=%0d want 0 0 0", out_valid, out_data, out_count);
    end
    do_reset();
    tick(1, 16'h0081, 2'd0, 1, 0);
    tick(0, '0, 2'd0, 1, 0);
    tick(0, '0, 2'd0, 1, 0);
    n_chk++; if (obs_ov !== 1'b1 || obs_od !== 16'h0005) begin n_fail++; $display("FAIL async_first got v=%b %h want v=1 0005", obs_ov, obs_od); end
    do_reset();
    for (int j = 0; j < 15; j++) tick(1, 16'($urandom), 2'($urandom_range(0, 3)), 1, 0);
    repeat (3) tick(0, '0, 2'd0, 1, 0);
    n_chk++; if (obs_cnt !== 4'hF) begin n_fail++; $display("FAIL count_allones got %0d want 15", obs_cnt); end
    tick(1, 16'h0042, 2'd0, 1, 0);
    repeat (3) tick(0, '0, 2'd0, 1, 0);
    n_chk++; if (obs_cnt !== 4'h0) begin n_fail++; $display("FAIL count_wrap got %0d want 0", obs_cnt); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      tick($urandom_range(0, 3) != 0, 16'($urandom), 2'($urandom_range(0, 3)),
           $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
      n_chk++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", c, obs_ready, exp_ready); end
      n_chk++; if (obs_ov !== exp_ov) begin n_fail++; $display("FAIL rnd_out_valid cyc %0d got %b want %b", c, obs_ov, exp_ov); end
      if (exp_ov) begin
        n_chk++; if (obs_od !== exp_od) begin n_fail++; $display("FAIL rnd_out_data cyc %0d got %h want %h", c, obs_od, exp_od); end
      end
      n_chk++; if (obs_cnt !== exp_cnt) begin n_fail++; $display("FAIL rnd_out_count cyc %0d got %0d want %0d", c, obs_cnt, exp_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_add_mode();
    test_modes();
    test_lanes();
    test_backpressure();
    test_flush();
    test_async_reset_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/leaf_nu.md
Name: leaf_nu

Overview:
- Multi-lane, pipelined successor to the single-lane theta/iota combine leaf.
- Each lane builds two derived terms from its input: a theta term (rotate-left) and an iota term (a temporal difference against the previous accepted sample).
- The two terms are combined under a run-time selectable mode and XORed with the original input.
- Adds a valid/ready handshake with full backpressure, a synchronous flush and an output transaction counter, so the block sits in streaming datapaths between handshaked producers and consumers.

Parameters:
- WIDTH, 32, bits per lane.
- LANES, 4, independent lanes processed in lockstep.
- ROT, 1, theta left-rotate amount; legal range 0..WIDTH-1 (elaboration assertion).
- CNT_W, 32, width of the output transaction counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of pipeline and history; takes priority over all handshakes.
- in_valid  input  1  producer has a sample.
- in_ready  output  1  block accepts a sample this cycle.
- in_data  input  LANES*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- in_mode  input  2  combine mode, captured with the sample.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  consumer takes the result.
- out_data  output  LANES*WIDTH  per-lane result, same packing as in_data.
- out_count  output  CNT_W  number of completed output transfers; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst high, asynchronous): s1_valid=0, out_valid=0, out_data=0, out_count=0, all per-lane history registers (prev_x)=0, captured mode=0. in_ready reads 1 once rst is low.
- Accept event: in_valid && in_ready. Transfer event: out_valid && out_ready.
- Stage-2 load enable: s2_en = !out_valid || out_ready.
- Stage-1 load enable: s1_en = !s1_valid || s2_en.
- in_ready = s1_en. It is combinationally dependent on out_ready; this is the documented behaviour.
- Stage 1, on accept, per lane, registered:
  - x1 = x
  - t = rotl(x, ROT)
  - i = x ^ prev_x
  - prev_x <= x
  - mode1 <= in_mode
- prev_x updates only on accept; it is never updated by stalls or bubbles.
- Stage 2, when s2_en && s1_valid, registered:
  - c by mode1: 0 gives t+i, 1 gives t-i, 2 gives t^i, 3 gives t.
  - Arithmetic is modulo 2^WIDTH; carry/borrow is discarded; lanes never interact.
  - out_data <= c ^ x1.
- Latency: 2 cycles from accept to out_valid with no backpressure. Throughput is 1 sample/cycle sustained.
- Backpressure: while out_valid && !out_ready, out_data and out_valid are held stable. Stage 1 holds if occupied. in_ready drops only when both stages are full and out_ready is low.
- Bubbles: when s2_en and !s1_valid, out_valid goes to 0 (or stays 0).
- out_count increments by 1 on every transfer event, wrapping from all-ones to 0.
- flush (synchronous, overrides everything in that cycle):
  - s1_valid=0, out_valid=0, prev_x=0.
  - A sample presented that cycle is not accepted (in_ready=0 while flush=1).
  - out_count is retained.
- Simultaneous transfer and accept: both occur in the same cycle with no bubble.
- rst asserted mid-stream: any in-flight data is discarded with no partial outputs; state returns to reset values immediately.

Decomposition:
- Package leaf_nu_pkg holds:
  - typedef enum logic [1:0] {MODE_ADD, MODE_SUB, MODE_XOR, MODE_PASS} nu_mode_e;
  - a rotl function parametrised by width and amount.
- One natural sub-module, leaf_nu_lane: per-lane stage-1 registers, prev_x and stage-2 combine. It is generated LANES times.
- The top level owns the handshake, valid bits, mode pipeline register and counter.

Test Plan:
1. WIDTH=8, LANES=2, ROT=1, out_ready=1, mode 0. Lane0 sends 0x81 then 0x01. Results are 0x05, then 0x83 (second computed as t=0x02, i=0x80), each 2 cycles after accept; out_count=2.
2. Fresh reset, mode 1, lane0 sends 0x10 → 0x00. Then mode 3 with 0x10 (prev=0x10) → 0x30. Mode is captured per sample and the values are correct back to back.
3. Mode 2 after reset, lane0 sends 0x81 → 0x03. Lane1 sends 0xFF in the same beat → 0xFF (t=0xFF, i=0xFF, c=0x00, result 0x00^0xFF); the lanes stay independent.
4. Stream 8 samples with out_ready low for 5 cycles mid-stream. out_data is held stable, in_ready falls once both stages are full, no sample is lost or duplicated, and the order is preserved.
5. flush asserted with both stages full. The next cycle has out_valid=0. The next sample is 0x81 in mode 0 → 0x05 (history cleared). out_count is unchanged across the flush.
6. rst asserted asynchronously mid-cycle with data in flight. Outputs go to zero without waiting for a clock edge. After release, the first result matches a fresh-reset reference. Preloading out_count to all-ones (CNT_W=4, 16 transfers) wraps it to 0.
